// File: rtl/apb_xfer_sequencer.sv
// APB master sequencer: decodes one command at a time to a PSELx line and runs SETUP/ENABLE.
// Latency: mapped command responds 3 cycles after accept, unmapped 1 cycle (2 if accepted during ENABLE).
// Backpressure: cmd_ready drops only in SETUP; rsp_* is a registered pulse with no backpressure.
module apb_xfer_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLAVES = 4,
    parameter int                SEL_LSB    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [NUM_SLAVES-1:0] PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W-1:0]     PRDATA
);
    localparam int          IDX_W   = $clog2(NUM_SLAVES);
    localparam int          TAG_LSB = SEL_LSB + IDX_W;
    localparam logic [31:0] NSL     = NUM_SLAVES;

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, ERR} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cmd_idx;
    logic             cmd_mapped;
    logic             accept;
    logic             err_pend;

    assign cmd_idx    = cmd_addr[TAG_LSB-1:SEL_LSB];
    assign cmd_mapped = (cmd_addr[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB])
                        && (32'(cmd_idx) < NSL);
    assign accept     = cmd_valid && cmd_ready;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ERR: state_nxt = accept ? (cmd_mapped ? SETUP : ERR) : IDLE;
            SETUP:     state_nxt = ENABLE;
            ENABLE:    state_nxt = accept ? (cmd_mapped ? SETUP : ERR) : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state != SETUP);
        PENABLE   = (state == ENABLE);
        PSELx     = '0;
        if (state == SETUP || state == ENABLE) PSELx[sel_idx] = 1'b1;
    end

    // Bus fields only move on a mapped accept so they hold across errors and idle time.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            sel_idx <= '0;
        end else if (accept && cmd_mapped) begin
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            sel_idx <= cmd_idx;
            if (cmd_write) PWDATA <= cmd_wdata;
        end
    end

    // An unmapped command accepted while ENABLE retires is deferred one cycle so both
    // responses get their own pulse, in order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            err_pend  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (state == ENABLE) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                err_pend  <= accept && !cmd_mapped;
            end else if (err_pend) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                err_pend  <= accept && !cmd_mapped;
            end else if (accept && !cmd_mapped) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_xfer_sequencer.sv
// Bench for apb_xfer_sequencer: vector table, multi-cycle corner sequences, randomized scoreboard.
module tb_apb_xfer_sequencer;
    localparam logic [31:0] K_XOR = 32'hA5A5_5A5A;
    localparam int          NRAND = 300;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic [31:0] prdata_fixed = '0;
    logic        prdata_fn = 1'b0;

    // Slave model: either a fixed word or an address-derived word.
    assign PRDATA = prdata_fn ? (PADDR ^ K_XOR) : prdata_fixed;

    apb_xfer_sequencer dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        err;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    vec_t  vecs[8];
    rsp_t  expq[$];
    rsp_t  e;
    int    n_tests = 0;
    int    n_fail = 0;
    logic  acc;
    logic  mapped;
    int    k, nrsp, first, sent, drain, phase, nphase;
    logic [3:0]  msel;
    logic [31:0] maddr;
    logic        mwr;
    logic [5:0]  exp_bus;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    function automatic logic in_window(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8400_0000);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 32'h8100_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b0010, 32'hDEAD_BEEF, 32'h8100_0010, 32'h0};
        vecs[1] = '{1'b1, 32'h8300_0004, 32'h1234_5678, 32'h0,         1'b0, 4'b1000, 32'h0,         32'h8300_0004, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'h8000_0100, 32'h0,         32'h0BAD_F00D, 1'b0, 4'b0001, 32'h0BAD_F00D, 32'h8000_0100, 32'h1234_5678};
        vecs[3] = '{1'b0, 32'h9000_0000, 32'h0,         32'h1111_1111, 1'b1, 4'b0000, 32'h0,         32'h8000_0100, 32'h1234_5678};
        vecs[4] = '{1'b1, 32'h8200_FFFC, 32'hCAFE_0001, 32'h0,         1'b0, 4'b0100, 32'h0,         32'h8200_FFFC, 32'hCAFE_0001};
        vecs[5] = '{1'b1, 32'h0100_0000, 32'h0000_1111, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h8200_FFFC, 32'hCAFE_0001};
        vecs[6] = '{1'b0, 32'h83FF_FFFC, 32'h0,         32'h0000_0007, 1'b0, 4'b1000, 32'h0000_0007, 32'h83FF_FFFC, 32'hCAFE_0001};
        vecs[7] = '{1'b0, 32'h8400_0000, 32'h0,         32'h2222_2222, 1'b1, 4'b0000, 32'h0,         32'h83FF_FFFC, 32'hCAFE_0001};

        // Reset state
        repeat (3) tick;
        chk("reset_bus", {PSELx, PENABLE, PWRITE, PADDR}, '0);
        chk("reset_pwdata", PWDATA, '0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        chk("reset_ready", cmd_ready, 1'b1);
        HRESETn = 1'b1;
        tick;
        chk("post_reset_idle", {PSELx, PENABLE, cmd_ready, rsp_valid}, {4'b0, 1'b0, 1'b1, 1'b0});

        // Single commands from idle
        for (int i = 0; i < 8; i++) begin
            cmd_write = vecs[i].wr; cmd_addr = vecs[i].addr; cmd_wdata = vecs[i].wdata;
            prdata_fixed = vecs[i].prdata; cmd_valid = 1'b1;
            chk($sformatf("vec%0d_ready", i), cmd_ready, 1'b1);
            tick;
            cmd_valid = 1'b0;
            chk($sformatf("vec%0d_setup", i), {PSELx, PENABLE}, {vecs[i].sel, 1'b0});
            chk($sformatf("vec%0d_paddr", i), PADDR, vecs[i].paddr);
            chk($sformatf("vec%0d_pwdata", i), PWDATA, vecs[i].pwdata);
            if (!vecs[i].err) begin
                chk($sformatf("vec%0d_pwrite", i), {PWRITE, cmd_ready, rsp_valid}, {vecs[i].wr, 1'b0, 1'b0});
                tick;
                chk($sformatf("vec%0d_enable", i), {PSELx, PENABLE, cmd_ready, rsp_valid}, {vecs[i].sel, 1'b1, 1'b1, 1'b0});
                tick;
            end
            chk($sformatf("vec%0d_rsp", i), {rsp_valid, rsp_err, rsp_rdata}, {1'b1, vecs[i].err, vecs[i].rdata});
            chk($sformatf("vec%0d_idle", i), {PSELx, PENABLE}, '0);
            tick;
            chk($sformatf("vec%0d_single", i), rsp_valid, 1'b0);
        end

        // Back-to-back writes to slaves 0,1,2 with cmd_valid held
        k = 0; nrsp = 0;
        cmd_write = 1'b1; cmd_addr = 32'h8000_0000; cmd_wdata = 32'h0000_1000; cmd_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            acc = cmd_valid && cmd_ready;
            tick;
            if (acc) begin
                k++;
                if (k < 3) begin
                    cmd_addr = 32'h8000_0000 + (k << 24);
                    cmd_wdata = 32'h0000_1000 + k;
                end else cmd_valid = 1'b0;
            end
            if (c < 6) chk($sformatf("b2b_bus%0d", c), {PSELx, PENABLE}, {4'b0001 << (c / 2), 1'(c % 2)});
            if (rsp_valid) nrsp++;
        end
        chk("b2b_rsp_count", nrsp, 3);
        chk("b2b_last_pwdata", PWDATA, 32'h0000_1002);
        tick;

        // Mapped read followed directly by an unmapped write
        k = 0; nrsp = 0; first = -1;
        cmd_write = 1'b0; cmd_addr = 32'h8200_0000; prdata_fixed = 32'h5555_AAAA; cmd_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            acc = cmd_valid && cmd_ready;
            tick;
            if (acc) begin
                if (k == 0) begin
                    cmd_write = 1'b1; cmd_addr = 32'hA000_0000; cmd_wdata = 32'hFFFF_0000;
                end else cmd_valid = 1'b0;
                k++;
            end
            if (rsp_valid) begin
                if (nrsp == 0) begin
                    first = c;
                    chk("bd_rsp0", {rsp_err, rsp_rdata}, {1'b0, 32'h5555_AAAA});
                end else begin
                    chk("bd_rsp1", {rsp_err, rsp_rdata, 32'(c - first)}, {1'b1, 32'h0, 32'd1});
                end
                nrsp++;
            end
        end
        chk("bd_count", nrsp, 2);
        chk("bd_first_latency", first, 2);
        chk("bd_pwdata_kept", PWDATA, 32'h0000_1002);

        // Reset asserted during ENABLE of a read
        cmd_write = 1'b0; cmd_addr = 32'h8100_0000; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("rst_mid_enable", {PSELx, PENABLE}, {4'b0010, 1'b1});
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_mid_bus", {PSELx, PENABLE, PADDR}, '0);
        chk("rst_mid_ready", cmd_ready, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick;
            chk($sformatf("rst_mid_norsp%0d", c), rsp_valid, 1'b0);
        end
        HRESETn = 1'b1;
        tick;
        chk("rst_release", {cmd_ready, rsp_valid, PSELx}, {1'b1, 1'b0, 4'b0});

        // Randomized traffic against the scoreboard
        prdata_fn = 1'b1;
        sent = 0; drain = 0; phase = 0;
        msel = '0; maddr = '0; mwr = 1'b0;
        for (int cyc = 0; cyc < 5000 && drain < 8; cyc++) begin
            if (!cmd_valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
                cmd_write = 1'($urandom);
                cmd_wdata = $urandom;
                if ($urandom_range(0, 9) < 7)
                    cmd_addr = 32'h8000_0000 + ($urandom_range(0, 3) << 24) + ($urandom & 32'h00FF_FFFC);
                else begin
                    cmd_addr = $urandom;
                    if (in_window(cmd_addr)) cmd_addr = cmd_addr ^ 32'h4000_0000;
                end
                cmd_valid = 1'b1;
            end
            acc = cmd_valid && cmd_ready;
            nphase = (phase == 1) ? 2 : 0;
            if (acc) begin
                mapped = in_window(cmd_addr);
                e.err = !mapped;
                e.rdata = (mapped && !cmd_write) ? (cmd_addr ^ K_XOR) : 32'h0;
                expq.push_back(e);
                if (mapped) begin
                    nphase = 1;
                    msel = 4'b0001 << ((cmd_addr - 32'h8000_0000) >> 24);
                    maddr = cmd_addr;
                    mwr = cmd_write;
                end
            end
            tick;
            phase = nphase;
            if (acc) begin
                cmd_valid = 1'b0;
                sent++;
            end
            if (sent >= NRAND && !cmd_valid) drain++;
            case (phase)
                1:       exp_bus = {msel, 1'b0, 1'b0};
                2:       exp_bus = {msel, 1'b1, 1'b1};
                default: exp_bus = {4'b0, 1'b0, 1'b1};
            endcase
            chk("rnd_bus", {PSELx, PENABLE, cmd_ready}, exp_bus);
            if (phase == 1) chk("rnd_addr", {PWRITE, PADDR}, {mwr, maddr});
            if (rsp_valid) begin
                if (expq.size() == 0) chk("rnd_extra_rsp", rsp_valid, 1'b0);
                else begin
                    e = expq.pop_front();
                    chk("rnd_rsp", {rsp_err, rsp_rdata}, {e.err, e.rdata});
                end
            end
        end
        chk("rnd_sent", sent, NRAND);
        chk("rnd_all_rsp", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
